uart_rx_fifo: RTL and testbench

- Receive-side byte buffer sitting directly downstream of the UART receiver. It captures each completed byte from the receiver's 8-bit parallel output and queues it for a host/consumer.
- Decouples the receiver's byte-completion timing from consumer read timing and flags lost bytes.
- Single clock domain: rx_clk, the same clock that drives the receiver.

---
 rtl/uart_rx_fifo_if.sv | 37 +++
 rtl/uart_rx_fifo.sv | 109 ++++++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and consumer-side signals of the UART RX byte FIFO
// almost_full exists only when UART_RX_FIFO_AF_EN is defined.
interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rd_en;
  logic          clr_ovf;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
`ifdef UART_RX_FIFO_AF_EN
  logic          almost_full;

  modport master (
    output rx_valid, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow, almost_full
  );
  modport slave (
    input  rx_valid, rx_data, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow, almost_full
  );
`else
  modport master (
    output rx_valid, rx_data, rd_en, clr_ovf,
    input  rd_data, rd_valid, empty, full, count, overflow
  );
  modport slave (
    input  rx_valid, rx_data, rd_en, clr_ovf,
    output rd_data, rd_valid, empty, full, count, overflow
  );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO buffering completed UART RX bytes with sticky overflow flag
// Define UART_RX_FIFO_AF_EN to add the registered almost_full output.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic          rx_clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH || AF_LEVEL > DEPTH) begin : g_param_check
    $error("uart_rx_fifo: DEPTH must be 2**AW (>=2) and AF_LEVEL <= DEPTH");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [AW:0]   count_next;
  logic          empty_q;
  logic          full_q;
  logic          ovf_q;
  logic          rd_valid_q;
  logic [7:0]    rd_data_q;
  logic          wr_ok;
  logic          rd_ok;
  logic          drop;

  // A full FIFO still accepts a byte when the same edge frees a slot.
  always_comb begin
    wr_ok      = bus.rx_valid & (~full_q | bus.rd_en);
    rd_ok      = bus.rd_en & ~empty_q;
    drop       = bus.rx_valid & full_q & ~bus.rd_en;
    count_next = count_q;
    if (wr_ok && !rd_ok) begin
      count_next = count_q + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      count_next = count_q - 1'b1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd_ok;
      count_q    <= count_next;
      empty_q    <= (count_next == '0);
      full_q     <= (count_next == FULL_CNT);
    end
  end

  // Set beats clear when a drop and clr_ovf land on the same edge.
  always_ff @(posedge rx_clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_AF_EN
  localparam logic [AW:0] AF_CNT = (AW+1)'(AF_LEVEL);
  logic af_q;

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (count_next >= AF_CNT);
    end
  end

  assign bus.almost_full = af_q;
`endif

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized and directed bench for uart_rx_fifo against a queue model
// Build with UART_RX_FIFO_AF_EN defined to also cover almost_full.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int AF_LEVEL = 12;

  logic rx_clk = 1'b0;
  logic rst;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL)) dut (
    .rx_clk (rx_clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 rx_clk = ~rx_clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q [$];
  logic       m_ovf;
  logic       m_rdv;
  logic [7:0] m_rdd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(bus.count), 32'(q.size()));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    check("full", 32'(bus.full), 32'(q.size() == DEPTH));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    check("rd_data", 32'(bus.rd_data), 32'(m_rdd));
`ifdef UART_RX_FIFO_AF_EN
    check("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF_LEVEL));
`endif
  endtask

  // One clock: drive, let the edge happen, advance the model, compare #1 later.
  task automatic step(input logic r, input logic rv, input logic [7:0] d,
                      input logic re, input logic clr);
    logic do_rd, do_wr;
    rst          = r;
    bus.rx_valid = rv;
    bus.rx_data  = d;
    bus.rd_en    = re;
    bus.clr_ovf  = clr;
    @(posedge rx_clk);
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_rdv = 1'b0;
      m_rdd = 8'h00;
    end else begin
      do_rd = re && (q.size() > 0);
      do_wr = rv && ((q.size() < DEPTH) || re);
      m_rdv = do_rd;
      if (do_rd) m_rdd = q.pop_front();
      if (do_wr) q.push_back(d);
      if (rv && !do_wr) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    m_ovf = 1'b0;
    m_rdv = 1'b0;
    m_rdd = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rd_en    = 1'b0;
    bus.clr_ovf  = 1'b0;
    rst = 1'b1;

    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
    idle();
    check("reset_rd_data", 32'(bus.rd_data), 32'h00);

    wr(8'hA5); wr(8'h3C); wr(8'hFF);
    check("order_count3", 32'(bus.count), 32'd3);
    rd(); check("order_0", 32'(bus.rd_data), 32'hA5);
    rd(); check("order_1", 32'(bus.rd_data), 32'h3C);
    rd(); check("order_2", 32'(bus.rd_data), 32'hFF);
    check("order_empty", 32'(bus.empty), 32'd1);
    idle();

    for (int i = 0; i < 16; i++) wr(8'(i));
    check("fill_full", 32'(bus.full), 32'd1);
    wr(8'hEE);
    check("drop_ovf", 32'(bus.overflow), 32'd1);
    check("drop_count", 32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd();
      check("drain_data", 32'(bus.rd_data), 32'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(bus.overflow), 32'd0);

    for (int i = 0; i < 16; i++) wr(8'(i));
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    check("fullrw_data", 32'(bus.rd_data), 32'h00);
    check("fullrw_count", 32'(bus.count), 32'd16);
    check("fullrw_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 16; i++) rd();
    check("fullrw_last", 32'(bus.rd_data), 32'h77);

    wr(8'h10); wr(8'h11);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    rd(); rd();
    check("wrap_last", 32'(bus.rd_data), 32'h47);
    rd();
    check("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("empty_rd_hold", 32'(bus.rd_data), 32'h47);
    step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
    check("empty_rw_count", 32'(bus.count), 32'd1);
    rd();

    for (int i = 0; i < 16; i++) wr(8'(i));
    step(1'b0, 1'b1, 8'hDD, 1'b0, 1'b1);
    check("clr_vs_drop", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 11; i++) rd();
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    wr(8'h5A); rd();
    check("midrst_data", 32'(bus.rd_data), 32'h5A);

`ifdef UART_RX_FIFO_AF_EN
    for (int i = 0; i < 12; i++) begin
      check("af_before", 32'(bus.almost_full), 32'd0);
      wr(8'(8'h80 + i));
    end
    check("af_set", 32'(bus.almost_full), 32'd1);
    rd();
    check("af_clear", 32'(bus.almost_full), 32'd0);
    for (int i = 0; i < 11; i++) rd();
`endif

    for (int n = 0; n < 3000; n++) begin
      logic wbias;
      wbias = ((n / 150) % 2) == 0;
      step(($urandom_range(0, 799) == 0),
           ($urandom_range(0, 99) < (wbias ? 75 : 30)),
           8'($urandom()),
           ($urandom_range(0, 99) < (wbias ? 30 : 75)),
           ($urandom_range(0, 99) < 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
